hazard_unit: RTL and testbench

- Pipeline-control counterpart to the operand-forwarding logic in the 5-stage MIPS core (IF/ID/EX/MEM/WB).
- Forwarding resolves operands for the consumer. This block covers the cases forwarding cannot resolve:
  - load-use stall,
  - taken-branch flush,
  - instruction/data memory wait,
  - end-of-program halt.
- Drives per-latch enable/flush controls and the PC enable, and keeps saturating stall/flush counters for performance reporting.

---
 rtl/hazard_unit.sv | 160 ++++++++++++++++
 tb/tb_hazard_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// hazard_unit
//
// Pipeline control for the 5-stage MIPS core. Operand forwarding handles
// most data dependencies; this block handles the cases forwarding cannot:
// load-use stalls, taken-branch flushes, instruction/data memory waits and
// the end-of-program halt. It drives per-latch enable/flush controls and
// the PC enable. It also keeps saturating stall/flush counters for
// performance reporting.
//
// Ports:
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   ihit, dhit           instruction fetch / data access completes this cycle
//   id_rs, id_rt         source registers of the instruction in ID
//   ex_rt, ex_dREN       destination and load flag of the instruction in EX
//   mem_dREN, mem_dWEN   MEM instruction reads / writes data memory
//   mem_branch_taken     branch in MEM resolved taken
//   wb_halt              halt instruction reaches WB
//   pc_en, *_en, *_flush latch controls (combinational, 0-cycle latency)
//   halted               sticky halt indication
//   stall_cnt            cycles with pc_en=0 outside HALT (saturating)
//   flush_cnt            taken-branch flush events (saturating)
//   dbg_state            current FSM state, for observation only
//
// Handshake note: ihit/dhit are single-cycle completion strobes. A memory
// request is considered outstanding in any cycle where it is asserted and
// its hit is low. No backpressure is applied to the memories themselves.
module hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       ex_rt,
    input  logic             ex_dREN,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             mem_branch_taken,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             memwb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        DWAIT    = 2'd2,
        HALT     = 2'd3
    } state_t;

    state_t state, state_nx;

    logic dreq;
    logic load_use;
    logic flush_evt;
    logic stall_evt;

    assign dreq = mem_dREN | mem_dWEN;

    // $0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign load_use = ex_dREN && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    // Priority chain. DWAIT behaves like RUN: the miss condition is simply
    // re-evaluated every cycle. A branch held by a data miss is flushed on
    // the cycle the miss resolves.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        exmem_flush = 1'b0;
        memwb_en    = 1'b1;
        memwb_flush = 1'b0;
        flush_evt   = 1'b0;
        state_nx    = RUN;

        if (state == HALT) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            state_nx = HALT;
        end else if (wb_halt) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            state_nx = HALT;
        end else if (dreq && !dhit) begin
            // Freeze everything upstream of MEM and feed WB a bubble.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
            state_nx    = DWAIT;
        end else if (mem_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            pc_en       = ihit;
            flush_evt   = 1'b1;
        end else if (load_use && (state != LU_STALL)) begin
            // Hold IF/ID, insert one bubble into EX.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            state_nx   = LU_STALL;
        end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    assign stall_evt = !pc_en && (state != HALT);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_evt && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign halted    = (state == HALT);
    assign dbg_state = state;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DWAIT = 2'd2;

    logic             CLK;
    logic             nRST;
    logic             ihit, dhit;
    logic [4:0]       id_rs, id_rt, ex_rt;
    logic             ex_dREN, mem_dREN, mem_dWEN, mem_branch_taken, wb_halt;
    logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic             exmem_en, exmem_flush, memwb_en, memwb_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [1:0]       dbg_state;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    hazard_unit #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt), .ex_dREN(ex_dREN),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
        .mem_branch_taken(mem_branch_taken), .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .exmem_flush(exmem_flush),
        .memwb_en(memwb_en), .memwb_flush(memwb_flush),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The core is either halted or not; the only other memory it needs is
    // whether the previous cycle was a load-use bubble.
    bit m_halted = 0;
    bit m_lu     = 0;
    int m_stall  = 0;
    int m_flush  = 0;

    // 0: already halted, 1..6: the rule that governs this cycle.
    function automatic int pick_rule();
        bit lu_hazard;
        lu_hazard = ex_dREN && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
        if (m_halted)                          return 0;
        if (wb_halt)                           return 1;
        if ((mem_dREN || mem_dWEN) && !dhit)   return 2;
        if (mem_branch_taken)                  return 3;
        if (lu_hazard && !m_lu)                return 4;
        if (!ihit)                             return 5;
        return 6;
    endfunction

    // {pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl, memwb_en, memwb_fl}
    function automatic logic [8:0] ctrl_of(input int r);
        bit pc, ie, ifl, de, dfl, ee, efl, we, wfl;
        pc = 1; ie = 1; de = 1; ee = 1; we = 1;
        ifl = 0; dfl = 0; efl = 0; wfl = 0;
        case (r)
            0, 1: begin pc = 0; ie = 0; de = 0; ee = 0; we = 0; end
            2:    begin pc = 0; ie = 0; de = 0; ee = 0; wfl = 1; end
            3:    begin pc = ihit; ifl = 1; dfl = 1; efl = 1; end
            4:    begin pc = 0; ie = 0; dfl = 1; end
            5:    begin pc = 0; ifl = 1; end
            default: ;
        endcase
        return {pc, ie, ifl, de, dfl, ee, efl, we, wfl};
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_halted = 0;
            m_lu     = 0;
            m_stall  = 0;
            m_flush  = 0;
        end else begin
            int r;
            logic [8:0] c;
            r = pick_rule();
            c = ctrl_of(r);
            if (r != 0) begin
                if (!c[8] && m_stall < CNT_MAX) m_stall++;
                if (r == 3 && m_flush < CNT_MAX) m_flush++;
                m_lu     = (r == 4);
                m_halted = (r == 1);
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    logic [17:0] exp_q[$];

    always @(negedge CLK) begin
        if (chk_en) begin
            logic [17:0] e, g;
            exp_q.push_back({ctrl_of(pick_rule()), m_halted,
                             4'(m_stall), 4'(m_flush)});
            g = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                 exmem_en, exmem_flush, memwb_en, memwb_flush,
                 halted, stall_cnt, flush_cnt};
            e = exp_q.pop_front();
            check("cycle_cmp", 32'(g), 32'(e));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        ihit = 1; dhit = 1;
        id_rs = 0; id_rt = 0; ex_rt = 0;
        ex_dREN = 0; mem_dREN = 0; mem_dWEN = 0;
        mem_branch_taken = 0; wb_halt = 0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 0;
        idle();
        step(1);
        nRST = 1;
        #1;
        check("rst_halted", 32'(halted), 0);
        check("rst_stall",  32'(stall_cnt), 0);
        check("rst_flush",  32'(flush_cnt), 0);
        check("rst_state",  32'(dbg_state), 32'(ST_RUN));
    endtask

    // ---------------- directed tests ----------------
    initial begin
        nRST = 0;
        idle();
        step(1);
        chk_en = 1;

        // Load-use on rs
        do_reset();
        ex_dREN = 1; ex_rt = 8; id_rs = 8; #1;
        check("lu_c0_pc",    32'(pc_en), 0);
        check("lu_c0_ifid",  32'(ifid_en), 0);
        check("lu_c0_idexf", 32'(idex_flush), 1);
        step(1);
        check("lu_c1_pc",    32'(pc_en), 1);
        check("lu_c1_idexf", 32'(idex_flush), 0);
        check("lu_c1_stall", 32'(stall_cnt), 1);
        step(1);
        idle();
        step(1);

        // $0 never stalls
        do_reset();
        ex_dREN = 1; ex_rt = 0; id_rt = 0; #1;
        check("r0_pc",    32'(pc_en), 1);
        check("r0_idexf", 32'(idex_flush), 0);
        step(1);
        check("r0_stall", 32'(stall_cnt), 0);

        // rt matching both sources: one bubble only
        ex_rt = 5; id_rs = 5; id_rt = 5;
        step(2);
        check("both_stall", 32'(stall_cnt), 1);
        idle();
        step(1);

        // Data miss for 3 cycles
        do_reset();
        mem_dREN = 1; dhit = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("dm_pc",    32'(pc_en), 0);
            check("dm_exmem", 32'(exmem_en), 0);
            check("dm_wbfl",  32'(memwb_flush), 1);
            step(1);
        end
        check("dm_state", 32'(dbg_state), 32'(ST_DWAIT));
        dhit = 1; #1;
        check("dm_hit_pc",   32'(pc_en), 1);
        check("dm_hit_wbfl", 32'(memwb_flush), 0);
        step(1);
        check("dm_stall", 32'(stall_cnt), 3);
        check("dm_run",   32'(dbg_state), 32'(ST_RUN));

        // Branch held by a store miss, flushed when dhit arrives
        mem_dREN = 0; mem_dWEN = 1; dhit = 0; mem_branch_taken = 1; #1;
        check("bm_ifidf", 32'(ifid_flush), 0);
        step(1);
        dhit = 1; #1;
        check("bm_ifidf_hit", 32'(ifid_flush), 1);
        step(1);
        check("bm_flush", 32'(flush_cnt), 1);
        idle();
        step(1);

        // Branch beats load-use
        do_reset();
        mem_branch_taken = 1; ex_dREN = 1; ex_rt = 8; id_rs = 8; #1;
        check("br_ifidf",  32'(ifid_flush), 1);
        check("br_idexf",  32'(idex_flush), 1);
        check("br_exmemf", 32'(exmem_flush), 1);
        check("br_pc",     32'(pc_en), 1);
        step(1);
        check("br_flush", 32'(flush_cnt), 1);
        check("br_run",   32'(dbg_state), 32'(ST_RUN));
        mem_branch_taken = 0; #1;
        check("br_then_lu_pc", 32'(pc_en), 0);
        step(1);
        idle();
        step(1);

        // Fetch miss saturates stall counter
        do_reset();
        ihit = 0; #1;
        check("im_pc",    32'(pc_en), 0);
        check("im_ifidf", 32'(ifid_flush), 1);
        check("im_idex",  32'(idex_en), 1);
        step(20);
        check("im_sat", 32'(stall_cnt), 15);
        idle();
        step(1);

        // Halt, then reset mid-halt
        do_reset();
        wb_halt = 1; #1;
        check("h_c0_pc",    32'(pc_en), 0);
        check("h_c0_memwb", 32'(memwb_en), 0);
        step(1);
        wb_halt = 0; ihit = 0; mem_branch_taken = 1; #1;
        check("h_halted", 32'(halted), 1);
        check("h_pc",     32'(pc_en), 0);
        check("h_ifidf",  32'(ifid_flush), 0);
        check("h_stall",  32'(stall_cnt), 1);
        step(3);
        check("h_hold_stall", 32'(stall_cnt), 1);
        check("h_hold_flush", 32'(flush_cnt), 0);
        check("h_hold_en",    32'(memwb_en), 0);
        nRST = 0; #1;
        check("hr_halted", 32'(halted), 0);
        check("hr_stall",  32'(stall_cnt), 0);
        check("hr_state",  32'(dbg_state), 32'(ST_RUN));
        idle();
        step(1);
        nRST = 1;
        step(2);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
